// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package prefetch_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int INSN_BYTES   = 4;

   // One buffered fetch: the instruction word and the address it came from.
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush, count, empty and full.
// Storage is not reset; consumers must qualify head with empty.
module prefetch_fifo
   import prefetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // pointer and occupancy tracking; flush discards everything including a same-cycle push
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // entry storage
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, keeps up to DEPTH fetches
// in flight or buffered, and hands instructions to the core via valid/ready.
// A redirect flushes the buffer and discards responses still in flight.
// Optional statistics counters are built when PREFETCH_STATS_EN is defined.
// XLEN must equal XLEN_DEFAULT since fetch_entry_t is sized from it.
module instr_prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0]     stat_redirects,
   output logic [31:0]     stat_dropped,
   output logic [31:0]     stat_empty_stall
`endif
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credit_used;
   logic            req_fire;
   logic            rsp_ok;
   logic            rsp_drop;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};

   // Buffered plus in-flight never exceeds DEPTH, so responses never need backpressure.
   assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
   assign mem_req_valid = rst && !redirect && (credit_used < CREDITS);
   assign mem_addr      = fetch_pc;
   assign req_fire      = mem_req_valid && mem_req_ready;

   // A response with nothing in flight is a protocol error and is ignored.
   assign rsp_ok           = mem_rsp_valid && (outstanding != '0);
   assign rsp_drop         = rsp_ok && ((drop_cnt != '0) || redirect);
   assign push             = rsp_ok && !rsp_drop;
   assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_ok);
   assign push_entry       = '{pc: rsp_pc, inst: mem_rsp_data};

   assign inst_valid = !fifo_empty;
   assign pop        = inst_valid && inst_ready && !redirect;
   assign inst       = fifo_empty ? '0 : head.inst;
   assign inst_pc    = fifo_empty ? '0 : head.pc;

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // fetch/response PCs, in-flight count and wrong-path drop count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect) begin
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
            drop_cnt <= outstanding_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);
            if (push)     rsp_pc   <= rsp_pc + XLEN'(INSN_BYTES);
            if (rsp_drop && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

`ifdef PREFETCH_STATS_EN
   // saturating event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_redirects   <= '0;
         stat_dropped     <= '0;
         stat_empty_stall <= '0;
      end else begin
         if (redirect && (stat_redirects != '1))
            stat_redirects <= stat_redirects + 32'd1;
         if (rsp_drop && (stat_dropped != '1))
            stat_dropped <= stat_dropped + 32'd1;
         if (inst_ready && !inst_valid && (stat_empty_stall != '1))
            stat_empty_stall <= stat_empty_stall + 32'd1;
      end
   end
`endif

   // memory must only answer fetches that are actually in flight
   assert property (@(posedge clk) disable iff (!rst) !(mem_rsp_valid && (outstanding == '0)));

   // credit accounting must keep the buffer from overflowing
   assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed scenarios plus a
// randomized run against a memory model and an expected instruction stream.
module tb_instr_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_redirects;
   logic [31:0] stat_dropped;
   logic [31:0] stat_empty_stall;
`endif

   instr_prefetch_buffer #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .inst_pc       (inst_pc)
`ifdef PREFETCH_STATS_EN
      ,
      .stat_redirects   (stat_redirects),
      .stat_dropped     (stat_dropped),
      .stat_empty_stall (stat_empty_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } mreq_t;

   mreq_t       q[$];
   int          cyc, last_due, epoch, lat;
   int          checks, errors, reqs, pops;
   int          exp_redirects, exp_dropped, exp_stall;
   logic [31:0] exp_req, exp_pc;
   logic        drv_redirect, drv_mready, drv_iready, rsp_en;
   logic [31:0] drv_target;
   logic        s_req_valid, s_inst_valid;
   logic [31:0] s_mem_addr, s_inst, s_inst_pc;
   logic        found;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // one clock cycle: drive at negedge, sample, update models, advance to next negedge
   task automatic tick();
      mreq_t r;
      redirect      = drv_redirect;
      redirect_pc   = drv_target;
      mem_req_ready = drv_mready;
      inst_ready    = drv_iready;
      mem_rsp_valid = rsp_en && (q.size() > 0) && (q[0].due <= cyc);
      mem_rsp_data  = mem_rsp_valid ? memf(q[0].addr) : 32'h0;
      #1;
      s_req_valid  = mem_req_valid;
      s_mem_addr   = mem_addr;
      s_inst_valid = inst_valid;
      s_inst       = inst;
      s_inst_pc    = inst_pc;
      if (drv_iready && !s_inst_valid) exp_stall++;
      if (drv_redirect) check("no_req_on_redirect", s_req_valid, 1'b0);
      if (s_inst_valid && drv_iready && !drv_redirect) begin
         check("inst_pc", s_inst_pc, exp_pc);
         check("inst", s_inst, memf(exp_pc));
         exp_pc += 32'd4;
         pops++;
      end
      if (s_req_valid && drv_mready) begin
         check("req_addr", s_mem_addr, exp_req);
         check("credit", q.size() < DEPTH, 1'b1);
         r.addr  = s_mem_addr;
         r.due   = cyc + lat;
         if (r.due <= last_due) r.due = last_due + 1;
         last_due = r.due;
         r.epoch = epoch;
         q.push_back(r);
         exp_req += 32'd4;
         reqs++;
      end
      if (mem_rsp_valid) begin
         if (drv_redirect || (q[0].epoch != epoch)) exp_dropped++;
         void'(q.pop_front());
      end
      if (drv_redirect) begin
         exp_pc  = {drv_target[31:2], 2'b00};
         exp_req = exp_pc;
         epoch++;
         exp_redirects++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // assert reset (called at a negedge), check async output values, release
   task automatic do_reset();
      rst           = 1'b0;
      redirect      = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      inst_ready    = 1'b0;
      #1;
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      q.delete();
      cyc = 0; last_due = -1; epoch = 0; reqs = 0; pops = 0;
      exp_req = RESET_PC; exp_pc = RESET_PC;
      exp_redirects = 0; exp_dropped = 0; exp_stall = 0;
      drv_redirect = 1'b0; drv_mready = 1'b1; drv_iready = 1'b1; rsp_en = 1'b1;
      drv_target = '0; lat = 1;
      repeat (2) @(negedge clk);
`ifdef PREFETCH_STATS_EN
      check("rst_stat_redirects", stat_redirects, 32'h0);
      check("rst_stat_dropped", stat_dropped, 32'h0);
      check("rst_stat_empty_stall", stat_empty_stall, 32'h0);
`endif
      rst = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (s_inst_valid) found = 1'b1;
      end
      if (!found) check(tag, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      checks = 0; errors = 0;
      @(negedge clk);

      // 1-cycle memory, core always ready
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t1_valid", s_inst_valid, (i >= 2));
         if (i == 0) check("t1_first_addr", s_mem_addr, RESET_PC);
         if (i >= 2 && i <= 4) check("t1_pc", s_inst_pc, 32'((i - 2) * 4));
      end

      // core stalled: credit limit caps requests at DEPTH
      do_reset();
      drv_iready = 1'b0;
      repeat (10) tick();
      check("t2_reqs", reqs, DEPTH);
      check("t2_req_stall", s_req_valid, 1'b0);
      drv_iready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (s_req_valid) begin
            found = 1'b1;
            check("t2_resume_addr", s_mem_addr, 32'h10);
         end
      end
      if (!found) check("t2_resume_timeout", 1'b0, 1'b1);
      repeat (8) tick();
      check("t2_drain", pops >= 4, 1'b1);

      // 3-cycle memory, redirect with two fetches in flight
      do_reset();
      lat = 3;
      repeat (2) tick();
      drv_mready = 1'b0; drv_redirect = 1'b1; drv_target = 32'h100;
      tick();
      drv_mready = 1'b1; drv_redirect = 1'b0;
      wait_valid("t3_timeout");
      check("t3_pc", s_inst_pc, 32'h100);
`ifdef PREFETCH_STATS_EN
      check("t3_dropped", stat_dropped, 32'd2);
      check("t3_redirects", stat_redirects, 32'd1);
`endif

      // redirect coinciding with a response and a would-be pop
      do_reset();
      drv_iready = 1'b0;
      repeat (3) tick();
      drv_iready = 1'b1; drv_redirect = 1'b1; drv_target = 32'h200;
      tick();
      check("t4_pre_valid", s_inst_valid, 1'b1);
      drv_redirect = 1'b0; drv_iready = 1'b0;
      tick();
      check("t4_flushed", s_inst_valid, 1'b0);
`ifdef PREFETCH_STATS_EN
      check("t4_dropped", stat_dropped, 32'd1);
`endif
      drv_iready = 1'b1;
      wait_valid("t4_timeout");
      check("t4_pc", s_inst_pc, 32'h200);

      // unaligned redirect target is word-aligned
      drv_redirect = 1'b1; drv_target = 32'h103;
      tick();
      drv_redirect = 1'b0;
      tick();
      check("t5_addr", s_mem_addr, 32'h100);

      // reset mid-operation with fetches in flight and entries buffered
      do_reset();
      lat = 3; drv_iready = 1'b0;
      repeat (5) tick();
      inst_ready = 1'b0; redirect = 1'b0; mem_rsp_valid = 1'b0;
      #1;
      check("t6_pre_valid", inst_valid, 1'b1);
      check("t6_pre_inst", inst, memf(32'h0));
      do_reset();
      #1;
      check("t6_post_req_valid", mem_req_valid, 1'b1);
      check("t6_post_addr", mem_addr, RESET_PC);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drv_iready   = ($urandom_range(0, 3) != 0);
         drv_mready   = ($urandom_range(0, 3) != 0);
         rsp_en       = ($urandom_range(0, 4) != 0);
         lat          = $urandom_range(1, 4);
         drv_redirect = ($urandom_range(0, 19) == 0);
         drv_target   = $urandom;
         tick();
      end
      drv_redirect = 1'b0; drv_iready = 1'b1; drv_mready = 1'b1; rsp_en = 1'b1;
      repeat (30) tick();
      check("rand_progress", pops > 200, 1'b1);
`ifdef PREFETCH_STATS_EN
      check("rand_redirects", stat_redirects, exp_redirects);
      check("rand_dropped", stat_dropped, exp_dropped);
      check("rand_empty_stall", stat_empty_stall, exp_stall);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
